// File: rtl/batalha_pkg.sv
// Shared battleship definitions: board geometry, ship types, shot-resolver
// FSM encoding and the ship-index -> ship-type map.
package batalha_pkg;

   localparam int NUM_NAVIOS = 11;
   localparam int ADDR_W     = 5;

   localparam logic [2:0] TIPO_SUB         = 3'd0;
   localparam logic [2:0] TIPO_CRUZADOR    = 3'd1;
   localparam logic [2:0] TIPO_HIDROAVIAO  = 3'd2;
   localparam logic [2:0] TIPO_ENCOURACADO = 3'd3;
   localparam logic [2:0] TIPO_PORTA_AVIAO = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CHK  = 3'd1,
      ST_RD   = 3'd2,
      ST_CMP  = 3'd3,
      ST_WR   = 3'd4,
      ST_DONE = 3'd5
   } estado_t;

   // Entries 0-4 submarines, 5-6 cruisers, 7-8 seaplane carriers,
   // 9 battleship, 10 aircraft carrier.
   function automatic logic [2:0] tipo_de_indice(input logic [4:0] idx);
      logic [2:0] t;
      t = TIPO_SUB;
      if (idx >= 5'd10)     t = TIPO_PORTA_AVIAO;
      else if (idx == 5'd9) t = TIPO_ENCOURACADO;
      else if (idx >= 5'd7) t = TIPO_HIDROAVIAO;
      else if (idx >= 5'd5) t = TIPO_CRUZADOR;
      return t;
   endfunction

endpackage

// File: rtl/resolvedor_disparo_tipo.sv
// tipo_por_indice: combinational ship-entry index -> ship type.
module tipo_por_indice
   import batalha_pkg::*;
(
   input  logic [4:0] idx_i,
   output logic [2:0] tipo_o
);

   assign tipo_o = tipo_de_indice(idx_i);

endmodule

// File: rtl/resolvedor_disparo.sv
// resolvedor_disparo: resolves one shot against the opponent's board RAM.
// Scans every ship entry, clears the hit cell by write-back, and reports
// hit / sunk / ship type / game over.
// Optional feature: define SHOT_HISTORY_EN to reject repeated shots.
module resolvedor_disparo #(
   parameter int NUM_NAVIOS = 11,
   parameter int ADDR_W     = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              jogador,
   input  logic [3:0]        x1,
   input  logic [3:0]        y1,
   input  logic [63:0]       vetor_leitura_jogadorUm,
   input  logic [63:0]       vetor_leitura_jogadorDois,
   output logic [ADDR_W-1:0] addr_jogadorUm,
   output logic [ADDR_W-1:0] addr_jogadorDois,
   output logic              wrep1,
   output logic              wrep2,
   output logic [63:0]       vetor,
   output logic              ready,
   output logic              acerto,
   output logic              afundou,
   output logic [2:0]        tipo_afundado,
   output logic              fim_jogo,
   output logic              erro_coord,
   output logic              repetido
);
   import batalha_pkg::*;

   estado_t             state_q, state_d;
   logic                enable_q, rearm_q;
   logic                jog_q, jog_d;
   logic [3:0]          x_q, x_d, y_q, y_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr1_q, addr1_d, addr2_q, addr2_d;
   logic [63:0]         vetor_q, vetor_d;
   logic                acerto_q, acerto_d, afundou_q, afundou_d;
   logic [2:0]          tipo_q, tipo_d;
   logic                fim_q, fim_d, erro_q, erro_d;
   logic                rep_any_w;

   logic [5:0]          pos_w;
   logic [63:0]         mask_w, rdata_w, post_w;
   logic                hit_w, last_w, start_w;
   logic [2:0]          tipo_w;

   assign pos_w   = {y_q[2:0], x_q[2:0]};
   assign mask_w  = 64'd1 << pos_w;
   assign rdata_w = jog_q ? vetor_leitura_jogadorUm : vetor_leitura_jogadorDois;
   assign post_w  = rdata_w & ~mask_w;
   assign hit_w   = |(rdata_w & mask_w);
   assign last_w  = (idx_q == ADDR_W'(NUM_NAVIOS - 1));
   // rearm_q blocks a start while enable is still high coming out of reset.
   assign start_w = (state_q == ST_IDLE) && enable && !enable_q && !rearm_q;

   tipo_por_indice u_tipo (.idx_i({{(5-ADDR_W){1'b0}}, idx_q}), .tipo_o(tipo_w));

`ifdef SHOT_HISTORY_EN
   // Fired-cell history; index 0 = player 1's board, 1 = player 2's board.
   logic [1:0][63:0] hist_q, hist_d;
   logic             rep_q, rep_d;
   assign rep_any_w = rep_d;
   assign repetido  = rep_q;
`else
   assign rep_any_w = 1'b0;
   assign repetido  = 1'b0;
`endif

   // Next-state and datapath updates for the scan FSM.
   always_comb begin
      logic             go_rd;
      logic [ADDR_W-1:0] rd_idx;
      state_d   = state_q;
      jog_d     = jog_q;
      x_d       = x_q;
      y_d       = y_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      addr1_d   = addr1_q;
      addr2_d   = addr2_q;
      vetor_d   = vetor_q;
      acerto_d  = acerto_q;
      afundou_d = afundou_q;
      tipo_d    = tipo_q;
      fim_d     = fim_q;
      erro_d    = erro_q;
      go_rd     = 1'b0;
      rd_idx    = idx_q + 1'b1;
`ifdef SHOT_HISTORY_EN
      hist_d    = hist_q;
      rep_d     = rep_q;
`endif
      case (state_q)
         ST_IDLE: if (start_w) begin
            state_d   = ST_CHK;
            jog_d     = jogador;
            x_d       = x1;
            y_d       = y1;
            cnt_d     = '0;
            acerto_d  = 1'b0;
            afundou_d = 1'b0;
            tipo_d    = '0;
            fim_d     = 1'b0;
            erro_d    = 1'b0;
`ifdef SHOT_HISTORY_EN
            rep_d     = 1'b0;
`endif
         end
         ST_CHK: begin
            rd_idx = '0;
            if (x_q[3] || y_q[3]) begin
               erro_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
`ifdef SHOT_HISTORY_EN
               if (hist_q[~jog_q][pos_w]) begin
                  rep_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  hist_d[~jog_q][pos_w] = 1'b1;
                  go_rd = 1'b1;
               end
`else
               go_rd = 1'b1;
`endif
            end
         end
         ST_RD: state_d = ST_CMP;
         ST_CMP: begin
            // post_w equals the read data on a miss, so it is always the
            // value the entry holds after this shot.
            if (post_w != 64'd0) cnt_d = cnt_q + 4'd1;
            if (hit_w) begin
               vetor_d = post_w;
               state_d = ST_WR;
               if (!acerto_q) begin
                  acerto_d  = 1'b1;
                  tipo_d    = tipo_w;
                  afundou_d = (post_w == 64'd0);
               end
            end else if (last_w) state_d = ST_DONE;
            else go_rd = 1'b1;
         end
         ST_WR: begin
            if (last_w) state_d = ST_DONE;
            else go_rd = 1'b1;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (go_rd) begin
         state_d = ST_RD;
         idx_d   = rd_idx;
         if (jog_q) addr1_d = rd_idx;
         else       addr2_d = rd_idx;
      end
      if (state_d == ST_DONE && state_q != ST_DONE)
         fim_d = (cnt_d == 4'd0) && !erro_d && !rep_any_w;
   end

   // State and result registers; reset returns to IDLE in any state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         enable_q  <= 1'b0;
         rearm_q   <= 1'b1;
         jog_q     <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         addr1_q   <= '0;
         addr2_q   <= '0;
         vetor_q   <= '0;
         acerto_q  <= 1'b0;
         afundou_q <= 1'b0;
         tipo_q    <= '0;
         fim_q     <= 1'b0;
         erro_q    <= 1'b0;
`ifdef SHOT_HISTORY_EN
         hist_q    <= '0;
         rep_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         enable_q  <= enable;
         rearm_q   <= rearm_q && enable;
         jog_q     <= jog_d;
         x_q       <= x_d;
         y_q       <= y_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         addr1_q   <= addr1_d;
         addr2_q   <= addr2_d;
         vetor_q   <= vetor_d;
         acerto_q  <= acerto_d;
         afundou_q <= afundou_d;
         tipo_q    <= tipo_d;
         fim_q     <= fim_d;
         erro_q    <= erro_d;
`ifdef SHOT_HISTORY_EN
         hist_q    <= hist_d;
         rep_q     <= rep_d;
`endif
      end
   end

   // Strobes decode from state and drop immediately under reset so an
   // interrupted write never reaches the RAM.
   assign wrep1 = (state_q == ST_WR) &&  jog_q && !reset;
   assign wrep2 = (state_q == ST_WR) && !jog_q && !reset;
   assign ready = (state_q == ST_DONE) && !reset;

   assign addr_jogadorUm   = addr1_q;
   assign addr_jogadorDois = addr2_q;
   assign vetor            = vetor_q;
   assign acerto           = acerto_q;
   assign afundou          = afundou_q;
   assign tipo_afundado    = tipo_q;
   assign fim_jogo         = fim_q;
   assign erro_coord       = erro_q;

endmodule

// File: tb/tb_resolvedor_disparo.sv
// Directed bench for resolvedor_disparo with two registered-read board RAMs.
module tb_resolvedor_disparo;

   logic        clk = 1'b0;
   logic        reset, enable, jogador;
   logic [3:0]  x1, y1;
   logic [63:0] rd1, rd2;
   logic [4:0]  addr1, addr2;
   logic        wrep1, wrep2, ready, acerto, afundou, fim_jogo, erro_coord, repetido;
   logic [63:0] vetor;
   logic [2:0]  tipo;

   logic [63:0] mem1 [0:10];
   logic [63:0] mem2 [0:10];
   logic        ld_en, ld_clr, ld_brd;
   logic [3:0]  ld_addr;
   logic [63:0] ld_data;

   int n_cmp = 0, n_err = 0;
   int rdy_cyc, n_wr1, n_wr2;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;

   always #5 clk = ~clk;

   resolvedor_disparo dut (
      .clk(clk), .reset(reset), .enable(enable), .jogador(jogador),
      .x1(x1), .y1(y1),
      .vetor_leitura_jogadorUm(rd1), .vetor_leitura_jogadorDois(rd2),
      .addr_jogadorUm(addr1), .addr_jogadorDois(addr2),
      .wrep1(wrep1), .wrep2(wrep2), .vetor(vetor), .ready(ready),
      .acerto(acerto), .afundou(afundou), .tipo_afundado(tipo),
      .fim_jogo(fim_jogo), .erro_coord(erro_coord), .repetido(repetido)
   );

   // Board RAMs: registered read, write on strobe, bench preload port.
   always @(posedge clk) begin
      if (ld_clr) begin
         for (int i = 0; i < 11; i++) begin
            mem1[i] <= 64'd0;
            mem2[i] <= 64'd0;
         end
      end else if (ld_en) begin
         if (ld_brd) mem2[ld_addr] <= ld_data;
         else        mem1[ld_addr] <= ld_data;
      end else begin
         if (wrep1 && addr1 < 5'd11) mem1[addr1[3:0]] <= vetor;
         if (wrep2 && addr2 < 5'd11) mem2[addr2[3:0]] <= vetor;
      end
      rd1 <= (addr1 < 5'd11) ? mem1[addr1[3:0]] : 64'd0;
      rd2 <= (addr2 < 5'd11) ? mem2[addr2[3:0]] : 64'd0;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clr_boards();
      @(negedge clk); ld_clr = 1'b1;
      @(negedge clk); ld_clr = 1'b0;
   endtask

   task automatic load(input logic brd, input logic [3:0] a, input logic [63:0] d);
      @(negedge clk); ld_en = 1'b1; ld_brd = brd; ld_addr = a; ld_data = d;
      @(negedge clk); ld_en = 1'b0;
   endtask

   // Fires one shot; counts cycles from the start edge (cycle 1 = first
   // cycle after it) until ready, scrambling the inputs after the start.
   task automatic shoot(input logic j, input logic [3:0] x, input logic [3:0] y);
      int cyc;
      @(negedge clk); jogador = j; x1 = x; y1 = y; enable = 1'b1;
      @(posedge clk);
      cyc = 0; rdy_cyc = -1; n_wr1 = 0; n_wr2 = 0; wr_addr = '0; wr_data = '0;
      while (rdy_cyc < 0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            jogador = ~j; x1 = 4'hF; y1 = 4'hE; enable = 1'b0;
         end
         if (wrep1) begin n_wr1++; wr_addr = addr1; wr_data = vetor; end
         if (wrep2) begin n_wr2++; wr_addr = addr2; wr_data = vetor; end
         if (ready) rdy_cyc = cyc;
      end
   endtask

   initial begin
      int nr, nw;
      reset = 1'b1; enable = 1'b0; jogador = 1'b0; x1 = '0; y1 = '0;
      ld_en = 1'b0; ld_clr = 1'b1; ld_brd = 1'b0; ld_addr = '0; ld_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", ready, 0);
      chk("rst_acerto", acerto, 0);
      chk("rst_addr1", addr1, 0);
      chk("rst_addr2", addr2, 0);
      chk("rst_vetor", vetor, 0);
      chk("rst_flags", {wrep1, wrep2, afundou, fim_jogo, erro_coord, repetido, tipo}, 0);
      reset = 1'b0; ld_clr = 1'b0;

      // 1: hit on the battleship, not sunk
      load(1'b1, 4'd9, 64'h0F);
      shoot(1'b0, 4'd2, 4'd0);
      chk("t1_ready_cyc", rdy_cyc, 25);
      chk("t1_acerto", acerto, 1);
      chk("t1_afundou", afundou, 0);
      chk("t1_tipo", tipo, 3);
      chk("t1_fim", fim_jogo, 0);
      chk("t1_nwr2", n_wr2, 1);
      chk("t1_nwr1", n_wr1, 0);
      chk("t1_wr_addr", wr_addr, 9);
      chk("t1_wr_data", wr_data, 64'h0B);
      chk("t1_mem", mem2[9], 64'h0B);

      // 2: last cell of the only ship -> sunk and game over
      clr_boards();
      load(1'b1, 4'd0, 64'h1);
      shoot(1'b0, 4'd0, 4'd0);
      chk("t2_ready_cyc", rdy_cyc, 25);
      chk("t2_acerto", acerto, 1);
      chk("t2_afundou", afundou, 1);
      chk("t2_tipo", tipo, 0);
      chk("t2_fim", fim_jogo, 1);
      chk("t2_mem", mem2[0], 0);

      // 3: miss on an empty cell while a ship remains
      load(1'b1, 4'd9, 64'h0B);
      shoot(1'b0, 4'd7, 4'd7);
      chk("t3_ready_cyc", rdy_cyc, 24);
      chk("t3_acerto", acerto, 0);
      chk("t3_strobes", n_wr1 + n_wr2, 0);
      chk("t3_fim", fim_jogo, 0);
      chk("t3_mem", mem2[9], 64'h0B);

      // 4: out-of-range column
      shoot(1'b0, 4'd8, 4'd0);
      chk("t4_ready_cyc", rdy_cyc, 2);
      chk("t4_erro", erro_coord, 1);
      chk("t4_acerto", acerto, 0);
      chk("t4_fim", fim_jogo, 0);
      chk("t4_strobes", n_wr1 + n_wr2, 0);
      chk("t4_addr2", addr2, 10);
      chk("t4_addr1", addr1, 0);

      // 5: reset in the WR cycle of a hit on entry 9 (WR is cycle 22)
      @(negedge clk); jogador = 1'b0; x1 = 4'd1; y1 = 4'd0; enable = 1'b1;
      @(posedge clk);
      repeat (22) @(negedge clk);
      chk("t5_wr_before", wrep2, 1);
      reset = 1'b1;
      #1;
      chk("t5_wr_in_reset", wrep2, 0);
      @(negedge clk);
      reset = 1'b0;
      chk("t5_rst_out", {ready, acerto, wrep1, wrep2, afundou, fim_jogo, erro_coord, tipo}, 0);
      chk("t5_rst_addr2", addr2, 0);
      chk("t5_rst_vetor", vetor, 0);
      chk("t5_mem", mem2[9], 64'h0B);
      nr = 0; nw = 0;
      repeat (8) begin
         @(negedge clk);
         if (ready) nr++;
         if (wrep1 || wrep2) nw++;
      end
      chk("t5_no_restart", {nr[7:0], nw[7:0], 3'b000, addr2}, 0);
      enable = 1'b0;
      @(negedge clk);
      shoot(1'b0, 4'd1, 4'd0);
      chk("t5_ready_cyc", rdy_cyc, 25);
      chk("t5_acerto", acerto, 1);
      chk("t5_tipo", tipo, 3);
      chk("t5_mem_after", mem2[9], 64'h09);

      // 6: same cell twice
      shoot(1'b0, 4'd3, 4'd3);
      chk("t6a_ready_cyc", rdy_cyc, 24);
      chk("t6a_acerto", acerto, 0);
      shoot(1'b0, 4'd3, 4'd3);
`ifdef SHOT_HISTORY_EN
      chk("t6b_ready_cyc", rdy_cyc, 2);
      chk("t6b_repetido", repetido, 1);
      chk("t6b_strobes", n_wr1 + n_wr2, 0);
`else
      chk("t6b_ready_cyc", rdy_cyc, 24);
      chk("t6b_repetido", repetido, 0);
      chk("t6b_acerto", acerto, 0);
`endif

      // 7: player 2 fires at player 1's aircraft carrier
      load(1'b0, 4'd10, 64'h200);
      shoot(1'b1, 4'd1, 4'd1);
      chk("t7_ready_cyc", rdy_cyc, 25);
      chk("t7_acerto", acerto, 1);
      chk("t7_afundou", afundou, 1);
      chk("t7_tipo", tipo, 4);
      chk("t7_fim", fim_jogo, 1);
      chk("t7_nwr1", n_wr1, 1);
      chk("t7_nwr2", n_wr2, 0);
      chk("t7_wr_addr", wr_addr, 10);
      chk("t7_mem", mem1[10], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
